// File: rtl/array_write_arbiter.sv
// Owns the register array write port: an init sweep after reset, then round-robin
// sharing among N_REQ result writers, one registered array write per clock.
module array_write_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DEPTH    = 32,
    parameter int INDEX_W  = 6,
    parameter int DATA_W   = 32,
    parameter bit INIT_IDX = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*INDEX_W-1:0] reqIndex,
    input  logic [N_REQ*DATA_W-1:0]  reqData,
    output logic [N_REQ-1:0]         grant,
    output logic                     initDone,
    output logic                     rangeErr,
    output logic [INDEX_W-1:0]       index,
    output logic [DATA_W-1:0]        writeData,
    output logic                     writeEnable
);
    localparam int                 PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [INDEX_W:0]   DEPTH_L  = (INDEX_W+1)'(DEPTH);
    localparam logic [INDEX_W-1:0] LAST_L   = INDEX_W'(DEPTH-1);
    localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(N_REQ-1);

    typedef enum logic {INIT, ARB} state_t;

    state_t             state, state_nx;
    logic [INDEX_W-1:0] initCount;
    logic [PTR_W-1:0]   rrPtr;
    logic [PTR_W-1:0]   cand;
    logic [PTR_W-1:0]   gntIdx;
    logic               gntVld;
    logic [INDEX_W-1:0] selIndex;
    logic [DATA_W-1:0]  selData;
    logic               selOob;

    // Round-robin search starting at rrPtr; first requesting source wins.
    always_comb begin
        grant  = '0;
        gntIdx = '0;
        gntVld = 1'b0;
        cand   = '0;
        if (state == ARB) begin
            for (int k = 0; k < N_REQ; k++) begin
                cand = PTR_W'((int'(rrPtr) + k) % N_REQ);
                if (!gntVld && req[cand]) begin
                    gntVld = 1'b1;
                    gntIdx = cand;
                end
            end
            grant[gntIdx] = gntVld;
        end
    end

    always_comb begin
        selIndex = reqIndex[int'(gntIdx)*INDEX_W +: INDEX_W];
        selData  = reqData[int'(gntIdx)*DATA_W +: DATA_W];
        selOob   = ({1'b0, selIndex} >= DEPTH_L);
    end

    always_comb begin
        state_nx = state;
        if (state == INIT && initCount == LAST_L)
            state_nx = ARB;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= INIT;
        else
            state <= state_nx;
    end

    // Write stage: registered array write one cycle after the grant / sweep step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            initCount   <= '0;
            rrPtr       <= '0;
            index       <= '0;
            writeData   <= '0;
            writeEnable <= 1'b0;
            initDone    <= 1'b0;
            rangeErr    <= 1'b0;
        end else if (state == INIT) begin
            index       <= initCount;
            writeData   <= INIT_IDX ? DATA_W'(initCount) : '0;
            writeEnable <= 1'b1;
            initCount   <= initCount + INDEX_W'(1);
            if (initCount == LAST_L)
                initDone <= 1'b1;
        end else if (gntVld) begin
            index       <= selIndex;
            writeData   <= selData;
            writeEnable <= !selOob;
            if (selOob)
                rangeErr <= 1'b1;
            rrPtr <= (gntIdx == LAST_PTR) ? '0 : gntIdx + PTR_W'(1);
        end else begin
            writeEnable <= 1'b0;
        end
    end
endmodule

// File: tb/tb_array_write_arbiter.sv
// Bench for array_write_arbiter: directed scenarios plus randomized requesters,
// all checked against a cycle-count/round-robin model held in the bench.
module tb_array_write_arbiter;
    localparam int N_REQ   = 4;
    localparam int DEPTH   = 32;
    localparam int INDEX_W = 6;
    localparam int DATA_W  = 32;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [N_REQ-1:0]         req;
    logic [N_REQ*INDEX_W-1:0] reqIndex;
    logic [N_REQ*DATA_W-1:0]  reqData;
    logic [N_REQ-1:0]         grant;
    logic                     initDone, rangeErr, writeEnable;
    logic [INDEX_W-1:0]       index;
    logic [DATA_W-1:0]        writeData;

    logic               r_req [N_REQ];
    logic [INDEX_W-1:0] r_idx [N_REQ];
    logic [DATA_W-1:0]  r_dat [N_REQ];

    int checks = 0;
    int errors = 0;

    // Model: cycles since reset release, round-robin pointer, expected write-port regs.
    int                 m_cyc, m_rr, m_gidx;
    logic [INDEX_W-1:0] m_index;
    logic [DATA_W-1:0]  m_data;
    logic               m_we, m_err;
    logic [N_REQ-1:0]   g_seen;
    int                 waitc [N_REQ];

    array_write_arbiter #(.N_REQ(N_REQ), .DEPTH(DEPTH), .INDEX_W(INDEX_W),
                          .DATA_W(DATA_W), .INIT_IDX(1'b1)) dut (
        .clk(clk), .rst(rst), .req(req), .reqIndex(reqIndex), .reqData(reqData),
        .grant(grant), .initDone(initDone), .rangeErr(rangeErr), .index(index),
        .writeData(writeData), .writeEnable(writeEnable)
    );

    always #5 clk = ~clk;

    always_comb begin
        req      = '0;
        reqIndex = '0;
        reqData  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req[i]                         = r_req[i];
            reqIndex[i*INDEX_W +: INDEX_W] = r_idx[i];
            reqData[i*DATA_W +: DATA_W]    = r_dat[i];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_pick();
        if (m_cyc < DEPTH) return -1;
        for (int k = 0; k < N_REQ; k++) begin
            int c;
            c = (m_rr + k) % N_REQ;
            if (r_req[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_step();
        if (m_cyc < DEPTH) begin
            m_index = INDEX_W'(m_cyc);
            m_data  = DATA_W'(m_cyc);
            m_we    = 1'b1;
        end else if (m_gidx >= 0) begin
            m_index = r_idx[m_gidx];
            m_data  = r_dat[m_gidx];
            if (int'(r_idx[m_gidx]) >= DEPTH) begin
                m_we  = 1'b0;
                m_err = 1'b1;
            end else begin
                m_we = 1'b1;
            end
            m_rr = (m_gidx + 1) % N_REQ;
        end else begin
            m_we = 1'b0;
        end
        if (m_cyc < 100000) m_cyc++;
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        #1;
        m_gidx = model_pick();
        g_seen = grant;
        chk("grant", grant, (m_gidx < 0) ? 64'd0 : (64'd1 << m_gidx));
        for (int i = 0; i < N_REQ; i++) begin
            if (m_cyc >= DEPTH && r_req[i]) begin
                if (g_seen[i]) begin
                    chk("fair_wait", (waitc[i] <= N_REQ-1) ? 0 : waitc[i], 0);
                    waitc[i] = 0;
                end else begin
                    waitc[i]++;
                end
            end else begin
                waitc[i] = 0;
            end
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("index", index, m_index);
        chk("writeData", writeData, m_data);
        chk("writeEnable", writeEnable, m_we);
        chk("initDone", initDone, (m_cyc >= DEPTH));
        chk("rangeErr", rangeErr, m_err);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_index", index, 0);
        chk("rst_data", writeData, 0);
        chk("rst_we", writeEnable, 0);
        chk("rst_done", initDone, 0);
        chk("rst_err", rangeErr, 0);
        m_cyc = 0; m_rr = 0; m_gidx = -1;
        m_index = '0; m_data = '0; m_we = 1'b0; m_err = 1'b0;
        for (int i = 0; i < N_REQ; i++) waitc[i] = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic new_payload(input int i);
        r_idx[i] = ($urandom_range(0, 15) == 0) ? INDEX_W'($urandom_range(32, 63))
                                                : INDEX_W'($urandom_range(0, 31));
        r_dat[i] = $urandom;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N_REQ; i++) r_req[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N_REQ; i++) begin
            r_req[i] = 1'b0; r_idx[i] = '0; r_dat[i] = '0; waitc[i] = 0;
        end
        @(negedge clk);

        // Plain sweep with no requests.
        do_reset();
        for (int c = 1; c <= DEPTH; c++) begin
            cycle();
            if (c == 1) chk("t1_first_idx", index, 0);
        end
        chk("t1_last_idx", index, 31);
        chk("t1_last_data", writeData, 32'd31);
        chk("t1_done", initDone, 1);
        cycle();
        chk("t1_we_off", writeEnable, 0);

        // Request held through the sweep is served on the first ARB cycle.
        do_reset();
        r_req[0] = 1'b1; r_idx[0] = 6'd5; r_dat[0] = 32'hABCD0123;
        for (int c = 0; c < DEPTH; c++) begin
            cycle();
            chk("t2_no_grant", g_seen, 0);
        end
        cycle();
        chk("t2_grant", g_seen, 4'b0001);
        chk("t2_idx", index, 5);
        chk("t2_data", writeData, 32'hABCD0123);
        chk("t2_we", writeEnable, 1);
        r_req[0] = 1'b0;

        // All four requesting from rrPtr=0: strict rotation, continuous writes.
        do_reset();
        for (int c = 0; c < DEPTH; c++) cycle();
        for (int i = 0; i < N_REQ; i++) begin
            r_req[i] = 1'b1; r_idx[i] = INDEX_W'(8 + i); r_dat[i] = 32'h100 + i;
        end
        for (int n = 0; n < 8; n++) begin
            cycle();
            chk("t3_grant", g_seen, 4'b0001 << (n % 4));
            chk("t3_idx", index, 8 + n);
            chk("t3_data", writeData, 32'h100 + n);
            chk("t3_we", writeEnable, 1);
            r_idx[n % 4] = INDEX_W'(12 + n);
            r_dat[n % 4] = 32'h104 + n;
        end
        clear_reqs();

        // Move rrPtr to 2, then req=0011 is served 0 then 1, leaving rrPtr at 2.
        r_req[1] = 1'b1; r_idx[1] = 6'd20;
        cycle();
        chk("t4_pre", g_seen, 4'b0010);
        r_req[1] = 1'b0;
        r_req[0] = 1'b1; r_req[1] = 1'b1;
        cycle();
        chk("t4_g0", g_seen, 4'b0001);
        r_req[0] = 1'b0;
        cycle();
        chk("t4_g1", g_seen, 4'b0010);
        for (int i = 0; i < N_REQ; i++) r_req[i] = 1'b1;
        cycle();
        chk("t4_ptr2", g_seen, 4'b0100);
        clear_reqs();

        // Out-of-range index: write suppressed, sticky error.
        r_req[1] = 1'b1; r_idx[1] = 6'd40; r_dat[1] = 32'hDEAD;
        cycle();
        chk("t5_grant", g_seen, 4'b0010);
        chk("t5_we", writeEnable, 0);
        chk("t5_err", rangeErr, 1);
        r_req[1] = 1'b0;
        repeat (3) cycle();
        r_req[0] = 1'b1; r_idx[0] = 6'd3;
        cycle();
        chk("t5_we_ok", writeEnable, 1);
        chk("t5_err_sticky", rangeErr, 1);
        r_req[0] = 1'b0;

        // Reset mid-sweep, and reset in ARB with a request pending.
        do_reset();
        for (int c = 0; c < 10; c++) cycle();
        chk("t6_mid_idx", index, 9);
        do_reset();
        for (int c = 0; c < DEPTH + 2; c++) cycle();
        r_req[2] = 1'b1; r_idx[2] = 6'd7; r_dat[2] = 32'h5A5A;
        do_reset();
        for (int c = 0; c < DEPTH; c++) cycle();
        cycle();
        chk("t6_pending", g_seen, 4'b0100);
        chk("t6_idx", index, 7);
        r_req[2] = 1'b0;

        // Randomized requesters honouring the handshake.
        for (int c = 0; c < 600; c++) begin
            if (c == 300) do_reset();
            for (int i = 0; i < N_REQ; i++) begin
                if (m_gidx == i) begin
                    r_req[i] = 1'($urandom_range(0, 1));
                    new_payload(i);
                end else if (!r_req[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        r_req[i] = 1'b1;
                        new_payload(i);
                    end
                end else if ($urandom_range(0, 29) == 0) begin
                    r_req[i] = 1'b0;
                end
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
